stage_wb_regfile: RTL

STAGE_WB_REGFILE -- requirements
Module: stage_wb_regfile

---
 rtl/stage_wb_regfile.sv | 71 +++++++
 1 files changed

// File: rtl/stage_wb_regfile.sv
// Writeback stage: result mux, 16-entry register file with two combinational read ports,
// and commit tracking. Optional macro WB_BYPASS_EN forwards the in-flight writeback to matching read ports.
module stage_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RF_WE_i,
  input  logic              WBSelect_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] AluResult_i,
  input  logic [3:0]        A3_i,
  input  logic [3:0]        A1_i,
  input  logic [3:0]        A2_i,
  output logic [DATA_W-1:0] RD1_o,
  output logic [DATA_W-1:0] RD2_o,
  output logic [DATA_W-1:0] WBData_o,
  output logic [3:0]        LastA3_o,
  output logic              LastValid_o,
  output logic [31:0]       WriteCount_o
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [31:0]       write_count;
  logic [3:0]        last_a3;
  logic              last_valid;
  logic              byp1;
  logic              byp2;

  assign WBData_o = WBSelect_i ? ReadData_i : AluResult_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (RF_WE_i) begin
      regs[A3_i] <= WBData_o;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_count <= '0;
      last_a3     <= '0;
      last_valid  <= 1'b0;
    end else begin
      last_valid <= RF_WE_i;
      if (RF_WE_i) begin
        write_count <= write_count + 32'd1;
        last_a3     <= A3_i;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp1 = !RST && RF_WE_i && (A3_i == A1_i);
  assign byp2 = !RST && RF_WE_i && (A3_i == A2_i);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Reset gating keeps reads at zero even while the async clear is settling.
  assign RD1_o = RST ? '0 : (byp1 ? WBData_o : regs[A1_i]);
  assign RD2_o = RST ? '0 : (byp2 ? WBData_o : regs[A2_i]);

  assign LastA3_o     = last_a3;
  assign LastValid_o  = last_valid;
  assign WriteCount_o = write_count;

endmodule
